text_writer: RTL and testbench
==============================

TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 SETUP_CYC, 2, cycles address/char are stable before the strobe rises.
REQ-002 STROBE_CYC, 3, cycles the strobe is held high.
REQ-003 HOLD_CYC, 2, cycles address/char stay stable after the strobe falls.
REQ-004 CLK  in  1  sole clock; all logic on rising edge.
REQ-005 RESETN  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  ASCII byte offered.
REQ-007 in_data  in  8  ASCII byte.
REQ-008 in_ready  out  1  writer accepts a byte this cycle.
REQ-009 addr_col  out  6  display column, 0..49.
REQ-010 addr_row  out  5  display row, 0..29.
REQ-011 char_out  out  6  glyph code.
REQ-012 wr_strobe  out  1  display write strobe; display latches while high.

Function
REQ-013 The grid SHALL be 50x30; the writable area SHALL be rows 1..28 x cols 1..48, and border cells SHALL never be written.
REQ-014 Handshake: the block SHALL accept a byte when in_valid && in_ready; in_ready SHALL be high only in IDLE and SHALL drop the cycle after acceptance.
REQ-015 FSM states SHALL be IDLE, DECODE, SETUP, STROBE, HOLD, CLEAR; transitions: IDLE->DECODE on accept; DECODE->SETUP; SETUP->STROBE after SETUP_CYC; STROBE->HOLD after STROBE_CYC; HOLD->(next pending write: SETUP | CLEAR continuation | IDLE).
REQ-016 addr/char SHALL change only on SETUP entry and SHALL be constant through SETUP, STROBE and HOLD.
REQ-017 Glyph map: 'A'-'Z' and 'a'-'z'->0..25; '0'-'9'->26..35; punctuation . , ! " # $ ( ) + - * / ' : ; = @ ? % ^ ->36..55 in that order; space->57; any other printable->53.
REQ-018 A printable byte SHALL write its glyph at the cursor, then advance col; col 48 SHALL wrap to col 1 of row+1; row 28 SHALL wrap to row 1 (no scroll).
REQ-019 0x0D SHALL set col=1; 0x0A SHALL set col=1 and row+1 with the same row wrap; neither SHALL write a glyph.
REQ-020 0x08 SHALL decrement col (saturating at 1) and write 57 at the new position; at col 1 no write.
REQ-021 0x0C SHALL enter CLEAR: write 57 to all 1344 writable cells in row-major order, then set cursor (1,1).
REQ-022 Other control bytes (<0x20, 0x7F) SHALL be dropped with no write; in_ready SHALL return within 2 cycles.
REQ-023 Per-write time SHALL be SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; the first SETUP cycle SHALL follow DECODE.

Reset
REQ-024 While RESETN is low: wr_strobe=0, in_ready=0, addr_col=0, addr_row=0, char_out=0, cursor=(1,1), state IDLE; wr_strobe SHALL fall asynchronously even mid-STROBE.
REQ-025 After RESETN rises, the block SHALL run a full CLEAR (REQ-021) before first asserting in_ready.

Configuration
REQ-026 With CURSOR_EN defined: after every cursor-moving operation the block SHALL write 56 at the new cursor; moves without a glyph write (CR, LF, BS) SHALL first write 57 at the old position; CLEAR SHALL end with 56 at (1,1).
REQ-027 Without CURSOR_EN: no glyph-56 writes; the write counts of REQ-018..021 are exact.

Structure
REQ-028 Package text_writer_pkg SHALL hold grid constants (COLS, ROWS, first/last writable row/col), glyph codes (GLYPH_BLANK=57, GLYPH_CURSOR=56, GLYPH_UNKNOWN=53) and the FSM state enum.
REQ-029 ASCII-to-glyph decode SHALL be a combinational sub-module ascii_to_glyph (8-bit in; 6-bit glyph plus printable/control flags out).

Verification
REQ-030 Reset release, no CURSOR_EN -> exactly 1344 strobes with char_out=57, none at border cells, then in_ready=1, cursor (1,1).
REQ-031 Send 'h' then 'I' -> writes (row1,col1,7) and (row1,col2,8); each strobe is high exactly 3 cycles, addr stable 2 cycles before and after.
REQ-032 49 x 'A' from (1,1) -> 48th write at (1,48); 49th at (2,1).
REQ-033 Cursor at (28,5), send 0x0A then 'Z' -> no write for LF; 'Z' writes (1,1,25).
REQ-034 CURSOR_EN, send 'B' at (3,3) -> writes (3,3,1) then (3,4,56); send 0x08 -> writes (3,4,57), (3,3,57), (3,3,56).
REQ-035 Drop RESETN during STROBE of a write -> wr_strobe low in the same cycle; after release, full CLEAR then in_ready=1.

Source files
------------

// File: rtl/text_writer_pkg.sv
// Shared grid geometry, glyph codes, write timing and FSM state for text_writer.
// CURSOR_EN selects the visible-cursor build.
package text_writer_pkg;

    localparam int COLS = 50;
    localparam int ROWS = 30;
    localparam logic [5:0] COL_FIRST = 6'd1;
    localparam logic [5:0] COL_LAST  = 6'(COLS - 2);
    localparam logic [4:0] ROW_FIRST = 5'd1;
    localparam logic [4:0] ROW_LAST  = 5'(ROWS - 2);

    localparam logic [5:0] GLYPH_BLANK   = 6'd57;
    localparam logic [5:0] GLYPH_CURSOR  = 6'd56;
    localparam logic [5:0] GLYPH_UNKNOWN = 6'd53;

    localparam int SETUP_CYC  = 2;
    localparam int STROBE_CYC = 3;
    localparam int HOLD_CYC   = 2;

`ifdef CURSOR_EN
    localparam bit CURSOR_ON = 1'b1;
`else
    localparam bit CURSOR_ON = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, DECODE, SETUP, STROBE, HOLD, CLEAR} state_t;

    typedef struct packed {
        logic [4:0] row;
        logic [5:0] col;
        logic [5:0] chr;
    } wr_t;

    function automatic logic [4:0] next_row(input logic [4:0] r);
        return (r == ROW_LAST) ? ROW_FIRST : r + 5'd1;
    endfunction

endpackage

// File: rtl/text_writer_ascii_to_glyph.sv
// ASCII byte to display glyph code, plus printable / control classification.
// Purely combinational; no state, no backpressure.
module ascii_to_glyph
    import text_writer_pkg::*;
(
    input  logic [7:0] code,
    output logic [5:0] glyph,
    output logic       printable,
    output logic       control
);

    always_comb begin
        printable = (code >= 8'h20) && (code <= 8'h7E);
        control   = (code < 8'h20) || (code == 8'h7F);
        glyph     = GLYPH_UNKNOWN;
        if (code >= 8'h41 && code <= 8'h5A)
            glyph = 6'(code - 8'h41);
        else if (code >= 8'h61 && code <= 8'h7A)
            glyph = 6'(code - 8'h61);
        else if (code >= 8'h30 && code <= 8'h39)
            glyph = 6'(code - 8'h30) + 6'd26;
        else begin
            case (code)
                8'h2E: glyph = 6'd36;
                8'h2C: glyph = 6'd37;
                8'h21: glyph = 6'd38;
                8'h22: glyph = 6'd39;
                8'h23: glyph = 6'd40;
                8'h24: glyph = 6'd41;
                8'h28: glyph = 6'd42;
                8'h29: glyph = 6'd43;
                8'h2B: glyph = 6'd44;
                8'h2D: glyph = 6'd45;
                8'h2A: glyph = 6'd46;
                8'h2F: glyph = 6'd47;
                8'h27: glyph = 6'd48;
                8'h3A: glyph = 6'd49;
                8'h3B: glyph = 6'd50;
                8'h3D: glyph = 6'd51;
                8'h40: glyph = 6'd52;
                8'h3F: glyph = 6'd53;
                8'h25: glyph = 6'd54;
                8'h5E: glyph = 6'd55;
                8'h20: glyph = GLYPH_BLANK;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/text_writer.sv
// Terminal-style text writer driving a 50x30 glyph display; CURSOR_EN adds a visible cursor.
// Latency: accept -> DECODE -> per write SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; full-screen clear after reset.
// Backpressure: in_ready high only in IDLE, dropped the cycle after a byte is accepted.
module text_writer
    import text_writer_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [5:0] addr_col,
    output logic [4:0] addr_row,
    output logic [5:0] char_out,
    output logic       wr_strobe
);

    state_t     state;
    logic [1:0] cnt;
    logic [7:0] byte_q;
    logic [4:0] cur_row, clr_row, nrow;
    logic [5:0] cur_col, clr_col, ncol;
    logic       clr_active, do_clear;
    wr_t        plan [3];
    wr_t        ops  [3];
    logic [1:0] plan_cnt, plan_idx, n_ops;
    logic [5:0] glyph;
    logic       printable, control;

    ascii_to_glyph u_dec (
        .code      (byte_q),
        .glyph     (glyph),
        .printable (printable),
        .control   (control)
    );

    // Writes produced by the latched byte, in issue order, and the resulting cursor.
    always_comb begin
        nrow     = cur_row;
        ncol     = cur_col;
        n_ops    = 2'd0;
        do_clear = 1'b0;
        for (int i = 0; i < 3; i++) ops[i] = '0;
        if (printable) begin
            if (cur_col == COL_LAST) begin
                ncol = COL_FIRST;
                nrow = next_row(cur_row);
            end else begin
                ncol = cur_col + 6'd1;
            end
            ops[0] = '{row: cur_row, col: cur_col, chr: glyph};
            ops[1] = '{row: nrow, col: ncol, chr: GLYPH_CURSOR};
            n_ops  = CURSOR_ON ? 2'd2 : 2'd1;
        end else if (control) begin
            case (byte_q)
                8'h0D, 8'h0A: begin
                    ncol   = COL_FIRST;
                    nrow   = (byte_q == 8'h0A) ? next_row(cur_row) : cur_row;
                    ops[0] = '{row: cur_row, col: cur_col, chr: GLYPH_BLANK};
                    ops[1] = '{row: nrow, col: ncol, chr: GLYPH_CURSOR};
                    n_ops  = CURSOR_ON ? 2'd2 : 2'd0;
                end
                8'h08: begin
                    if (cur_col > COL_FIRST) begin
                        ncol = cur_col - 6'd1;
                        if (CURSOR_ON) begin
                            ops[0] = '{row: cur_row, col: cur_col, chr: GLYPH_BLANK};
                            ops[1] = '{row: cur_row, col: ncol, chr: GLYPH_BLANK};
                            ops[2] = '{row: cur_row, col: ncol, chr: GLYPH_CURSOR};
                            n_ops  = 2'd3;
                        end else begin
                            ops[0] = '{row: cur_row, col: ncol, chr: GLYPH_BLANK};
                            n_ops  = 2'd1;
                        end
                    end
                end
                8'h0C: begin
                    do_clear = 1'b1;
                    nrow     = ROW_FIRST;
                    ncol     = COL_FIRST;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            byte_q     <= 8'd0;
            in_ready   <= 1'b0;
            wr_strobe  <= 1'b0;
            addr_row   <= 5'd0;
            addr_col   <= 6'd0;
            char_out   <= 6'd0;
            cur_row    <= ROW_FIRST;
            cur_col    <= COL_FIRST;
            clr_active <= 1'b1;
            clr_row    <= ROW_FIRST;
            clr_col    <= COL_FIRST;
            plan[0]    <= '{row: ROW_FIRST, col: COL_FIRST, chr: GLYPH_CURSOR};
            plan[1]    <= '0;
            plan[2]    <= '0;
            plan_cnt   <= CURSOR_ON ? 2'd1 : 2'd0;
            plan_idx   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_active) begin
                        state <= CLEAR;
                    end else if (in_valid && in_ready) begin
                        byte_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    cur_row <= nrow;
                    cur_col <= ncol;
                    if (do_clear) begin
                        clr_active <= 1'b1;
                        clr_row    <= ROW_FIRST;
                        clr_col    <= COL_FIRST;
                        plan[0]    <= '{row: ROW_FIRST, col: COL_FIRST, chr: GLYPH_CURSOR};
                        plan_cnt   <= CURSOR_ON ? 2'd1 : 2'd0;
                        plan_idx   <= 2'd0;
                        state      <= CLEAR;
                    end else if (n_ops != 2'd0) begin
                        {addr_row, addr_col, char_out} <= ops[0];
                        plan     <= ops;
                        plan_cnt <= n_ops;
                        plan_idx <= 2'd1;
                        cnt      <= 2'd0;
                        state    <= SETUP;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                CLEAR: begin
                    {addr_row, addr_col, char_out} <= {clr_row, clr_col, GLYPH_BLANK};
                    if (clr_col == COL_LAST) begin
                        clr_col <= COL_FIRST;
                        if (clr_row == ROW_LAST) clr_active <= 1'b0;
                        else                     clr_row    <= clr_row + 5'd1;
                    end else begin
                        clr_col <= clr_col + 6'd1;
                    end
                    cnt   <= 2'd0;
                    state <= SETUP;
                end
                SETUP: begin
                    if (cnt == 2'(SETUP_CYC - 1)) begin
                        cnt       <= 2'd0;
                        wr_strobe <= 1'b1;
                        state     <= STROBE;
                    end else cnt <= cnt + 2'd1;
                end
                STROBE: begin
                    if (cnt == 2'(STROBE_CYC - 1)) begin
                        cnt       <= 2'd0;
                        wr_strobe <= 1'b0;
                        state     <= HOLD;
                    end else cnt <= cnt + 2'd1;
                end
                HOLD: begin
                    if (cnt == 2'(HOLD_CYC - 1)) begin
                        cnt <= 2'd0;
                        if (clr_active) begin
                            state <= CLEAR;
                        end else if (plan_idx < plan_cnt) begin
                            {addr_row, addr_col, char_out} <= plan[plan_idx];
                            plan_idx <= plan_idx + 2'd1;
                            state    <= SETUP;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end else cnt <= cnt + 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_writer.sv
// Randomized self-checking bench for text_writer against a screen-level model of expected writes.
module tb_text_writer;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [5:0] addr_col;
    logic [4:0] addr_row;
    logic [5:0] char_out;
    logic       wr_strobe;

`ifdef CURSOR_EN
    localparam bit CUR = 1'b1;
`else
    localparam bit CUR = 1'b0;
`endif

    localparam logic [7:0] PUNCT [20] = '{8'h2E, 8'h2C, 8'h21, 8'h22, 8'h23, 8'h24, 8'h28, 8'h29,
                                          8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h27, 8'h3A, 8'h3B, 8'h3D,
                                          8'h40, 8'h3F, 8'h25, 8'h5E};

    int checks = 0;
    int errors = 0;
    int nwrites = 0;
    int mrow, mcol;
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];

    text_writer dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .addr_col  (addr_col),
        .addr_row  (addr_row),
        .char_out  (char_out),
        .wr_strobe (wr_strobe)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [16:0] wr(input int r, input int c, input int g);
        return {5'(r), 6'(c), 6'(g)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, got, expv);
        end
    endtask

    // ---------------- screen-level reference model ----------------
    function automatic int mglyph(input logic [7:0] b);
        if (b >= 8'h41 && b <= 8'h5A) return int'(b) - 65;
        if (b >= 8'h61 && b <= 8'h7A) return int'(b) - 97;
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48 + 26;
        for (int i = 0; i < 20; i++)
            if (PUNCT[i] == b) return 36 + i;
        if (b == 8'h20) return 57;
        return 53;
    endfunction

    function automatic void model_clear();
        for (int r = 1; r <= 28; r++)
            for (int c = 1; c <= 48; c++) exp_q.push_back(wr(r, c, 57));
        mrow = 1;
        mcol = 1;
        if (CUR) exp_q.push_back(wr(1, 1, 56));
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int orow = mrow;
        int ocol = mcol;
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back(wr(mrow, mcol, mglyph(b)));
            if (mcol == 48) begin
                mcol = 1;
                mrow = (mrow == 28) ? 1 : mrow + 1;
            end else mcol++;
            if (CUR) exp_q.push_back(wr(mrow, mcol, 56));
        end else if (b == 8'h0D || b == 8'h0A) begin
            mcol = 1;
            if (b == 8'h0A) mrow = (mrow == 28) ? 1 : mrow + 1;
            if (CUR) begin
                exp_q.push_back(wr(orow, ocol, 57));
                exp_q.push_back(wr(mrow, mcol, 56));
            end
        end else if (b == 8'h08) begin
            if (mcol > 1) begin
                if (CUR) exp_q.push_back(wr(orow, ocol, 57));
                mcol--;
                exp_q.push_back(wr(mrow, mcol, 57));
                if (CUR) exp_q.push_back(wr(mrow, mcol, 56));
            end
        end else if (b == 8'h0C) begin
            model_clear();
        end
    endfunction

    // ---------------- per-cycle compare process ----------------
    int          cyc = 0;
    int          last_chg = 0;
    int          last_fall = -100;
    int          hi = 0;
    logic        prev_stb = 1'b0;
    logic [16:0] prev_a = '0;

    always @(negedge CLK) begin : cmp
        logic [16:0] a;
        logic [16:0] e;
        a = {addr_row, addr_col, char_out};
        if (!RESETN) begin
            prev_stb  = 1'b0;
            hi        = 0;
            last_fall = -100;
            prev_a    = a;
            last_chg  = cyc;
        end else begin
            cyc++;
            if (a != prev_a) begin
                check("addr_hold_after_strobe", (cyc - last_fall >= 2) && !wr_strobe, 1);
                last_chg = cyc;
                prev_a   = a;
            end
            if (wr_strobe && !prev_stb) begin
                check("addr_setup_before_strobe", cyc - last_chg >= 2, 1);
                check("no_border_write", addr_row >= 1 && addr_row <= 28 && addr_col >= 1 && addr_col <= 48, 1);
                got_q.push_back(a);
                nwrites++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got row %0d col %0d char %0d, required no write",
                             addr_row, addr_col, char_out);
                end else begin
                    e = exp_q.pop_front();
                    check("write_row_col_char", a, e);
                end
            end
            if (wr_strobe) hi++;
            if (!wr_strobe && prev_stb) begin
                check("strobe_width", hi, 3);
                hi        = 0;
                last_fall = cyc;
            end
            prev_stb = wr_strobe;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge CLK);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte 'h%0h not accepted, required acceptance", b);
            in_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (!in_ready && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check("ready_timeout", in_ready, 1);
        check("pending_writes", exp_q.size(), 0);
    endtask

    task automatic put(input logic [7:0] b);
        int n;
        send(b);
        wait_ready(200, n);
    endtask

    logic [7:0] gb [9] = '{8'h3F, 8'h7E, 8'h20, 8'h5E, 8'h30, 8'h39, 8'h7A, 8'h22, 8'h2E};
    int         ge [9] = '{53, 53, 57, 55, 26, 35, 25, 39, 36};

    initial begin
        int n;
        logic [7:0] b;
        RESETN   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge CLK);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_addr_col", addr_col, 0);
        check("rst_addr_row", addr_row, 0);
        check("rst_char_out", char_out, 0);

        model_clear();
        nwrites = 0;
        @(posedge CLK);
        #2 RESETN = 1'b1;
        wait_ready(12000, n);
        check("boot_clear_writes", nwrites, CUR ? 1345 : 1344);

`ifdef CURSOR_EN
        put(8'h0D); put(8'h0A); put(8'h0A); put(8'h78); put(8'h78);
        got_q.delete();
        put(8'h42);
        check("cur_B_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("cur_B_glyph", got_q[0], wr(3, 3, 1));
            check("cur_B_cursor", got_q[1], wr(3, 4, 56));
        end
        got_q.delete();
        put(8'h08);
        check("cur_bs_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("cur_bs_erase_old", got_q[0], wr(3, 4, 57));
            check("cur_bs_blank_new", got_q[1], wr(3, 3, 57));
            check("cur_bs_cursor", got_q[2], wr(3, 3, 56));
        end
`else
        got_q.delete();
        put(8'h68);
        put(8'h49);
        check("hI_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("h_write", got_q[0], wr(1, 1, 7));
            check("I_write", got_q[1], wr(1, 2, 8));
        end
        send(8'h0D);
        wait_ready(200, n);
        check("cr_ready_latency", n <= 2, 1);
        got_q.delete();
        repeat (49) put(8'h41);
        check("wrap_count", got_q.size(), 49);
        if (got_q.size() == 49) begin
            check("wrap_48th", got_q[47], wr(1, 48, 0));
            check("wrap_49th", got_q[48], wr(2, 1, 0));
        end
        got_q.delete();
        repeat (26) put(8'h0A);
        check("lf_no_writes", got_q.size(), 0);
        repeat (4) put(8'h41);
        got_q.delete();
        put(8'h0A);
        put(8'h5A);
        check("row_wrap_count", got_q.size(), 1);
        if (got_q.size() == 1) check("row_wrap_Z", got_q[0], wr(1, 1, 25));
        for (int i = 0; i < 9; i++) begin
            check("model_glyph", mglyph(gb[i]), ge[i]);
            got_q.delete();
            put(gb[i]);
            check("dut_glyph_count", got_q.size(), 1);
            if (got_q.size() == 1) check("dut_glyph", got_q[0][5:0], ge[i]);
        end
        put(8'h0D);
        got_q.delete();
        put(8'h08);
        check("bs_col1_no_write", got_q.size(), 0);
        put(8'h41);
        got_q.delete();
        put(8'h08);
        check("bs_count", got_q.size(), 1);
        if (got_q.size() == 1) check("bs_write", got_q[0], wr(1, 1, 57));
        got_q.delete();
        send(8'h01);
        wait_ready(200, n);
        check("drop_ready_latency", n <= 2, 1);
        check("drop_no_write", got_q.size(), 0);
`endif

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: b = 8'($urandom_range(32, 126));
                6: b = 8'h0D;
                7: b = 8'h0A;
                8: b = 8'h08;
                default: begin
                    b = 8'($urandom_range(0, 32));
                    if (b == 8'h0C || b == 8'h20) b = 8'h7F;
                end
            endcase
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            send(b);
        end
        wait_ready(200, n);

        nwrites = 0;
        send(8'h0C);
        wait_ready(12000, n);
        check("ff_clear_writes", nwrites, CUR ? 1345 : 1344);
        got_q.delete();
        put(8'h71);
        check("after_ff_first", got_q.size() > 0 ? got_q[0] : 17'h1ffff, wr(1, 1, 16));

        send(8'h6B);
        n = 0;
        while (!wr_strobe && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("strobe_seen_before_reset", wr_strobe, 1);
        @(posedge CLK);
        #2;
        check("strobe_high_mid_pulse", wr_strobe, 1);
        RESETN = 1'b0;
        #1;
        check("strobe_async_fall", wr_strobe, 0);
        check("ready_low_in_reset", in_ready, 0);
        exp_q.delete();
        got_q.delete();
        repeat (2) @(negedge CLK);
        check("reset_addr_row", addr_row, 0);
        check("reset_char_out", char_out, 0);
        model_clear();
        nwrites = 0;
        @(posedge CLK);
        #2 RESETN = 1'b1;
        wait_ready(12000, n);
        check("reset_clear_writes", nwrites, CUR ? 1345 : 1344);
        got_q.delete();
        put(8'h78);
        check("after_reset_first", got_q.size() > 0 ? got_q[0] : 17'h1ffff, wr(1, 1, 23));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
